// File: rtl/aes_ctr_block_gen.sv
// GCM counter-block generator: emits J0, then inc32 counter blocks for the
// plaintext, with valid/ready handshaking toward the AES round pipeline.
module aes_ctr_block_gen #(
    parameter int CNT_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic [0:95]  i_iv,
    input  logic [0:63]  i_aad_len,
    input  logic [0:63]  i_pt_len,
    input  logic         i_ready,
    // Test hook: when set at start, J0's low word is i_ctr_init instead of 1
    input  logic         i_ctr_load,
    input  logic [0:31]  i_ctr_init,
    output logic         o_valid,
    output logic [0:127] o_counter_block,
    output logic         o_is_j0,
    output logic         o_new_instance,
    output logic         o_last,
    output logic [0:127] o_instance_size,
    output logic         o_busy
);

    typedef enum logic [1:0] {IDLE, EMIT_J0, EMIT_CTR, DRAIN} state_t;

    state_t          state, state_nxt;
    logic [0:127]    block, block_nxt;
    logic [0:127]    size, size_nxt;
    logic [CNT_W-1:0] n, n_nxt;
    logic [64:0]     pt_round;
    logic [64:0]     pt_blocks;
    logic [0:127]    block_inc;
    logic            xfer;

    // 65-bit sum so a near-max pt_len cannot wrap before the shift
    assign pt_round  = {1'b0, i_pt_len} + 65'd127;
    assign pt_blocks = pt_round >> 7;
    assign block_inc = {block[0:95], block[96:127] + 32'd1};

    assign o_valid         = (state == EMIT_J0) || (state == EMIT_CTR);
    assign o_is_j0         = (state == EMIT_J0);
    assign o_new_instance  = (state == EMIT_J0);
    assign o_last          = ((state == EMIT_J0) && (n == '0)) ||
                             ((state == EMIT_CTR) && (n == CNT_W'(1)));
    assign o_busy          = (state != IDLE);
    assign o_counter_block = block;
    assign o_instance_size = size;
    assign xfer            = o_valid && i_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            block <= '0;
            size  <= '0;
            n     <= '0;
        end else begin
            state <= state_nxt;
            block <= block_nxt;
            size  <= size_nxt;
            n     <= n_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        block_nxt = block;
        size_nxt  = size;
        n_nxt     = n;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_nxt = EMIT_J0;
                    block_nxt = {i_iv, (i_ctr_load ? i_ctr_init : 32'h00000001)};
                    size_nxt  = {i_aad_len, i_pt_len};
                    n_nxt     = CNT_W'(pt_blocks);
                end
            end
            EMIT_J0: begin
                if (xfer) begin
                    if (n == '0) begin
                        state_nxt = DRAIN;
                    end else begin
                        state_nxt = EMIT_CTR;
                        block_nxt = block_inc;
                    end
                end
            end
            EMIT_CTR: begin
                if (xfer) begin
                    n_nxt     = n - CNT_W'(1);
                    block_nxt = block_inc;
                    if (n == CNT_W'(1))
                        state_nxt = DRAIN;
                end
            end
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_aes_ctr_block_gen.sv
// Scoreboard bench: the driver pushes the expected block sequence of each
// instance; a negedge monitor checks every presented block against the queue head.
module tb_aes_ctr_block_gen;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_start;
    logic [0:95]  i_iv;
    logic [0:63]  i_aad_len;
    logic [0:63]  i_pt_len;
    logic         i_ready;
    logic         i_ctr_load;
    logic [0:31]  i_ctr_init;
    logic         o_valid;
    logic [0:127] o_counter_block;
    logic         o_is_j0;
    logic         o_new_instance;
    logic         o_last;
    logic [0:127] o_instance_size;
    logic         o_busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [127:0] blk;
        logic         j0;
        logic         last;
        logic [127:0] size;
    } exp_t;

    exp_t q[$];

    aes_ctr_block_gen #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_iv(i_iv),
        .i_aad_len(i_aad_len), .i_pt_len(i_pt_len), .i_ready(i_ready),
        .i_ctr_load(i_ctr_load), .i_ctr_init(i_ctr_init),
        .o_valid(o_valid), .o_counter_block(o_counter_block), .o_is_j0(o_is_j0),
        .o_new_instance(o_new_instance), .o_last(o_last),
        .o_instance_size(o_instance_size), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every valid cycle is compared with the queue head; pop on transfer
    always @(negedge clk) begin
        if (o_valid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_block actual=%h expected=none", o_counter_block);
            end else begin
                chk("block", o_counter_block, q[0].blk);
                chk("flags", {125'd0, o_is_j0, o_new_instance, o_last},
                    {125'd0, q[0].j0, q[0].j0, q[0].last});
                chk("inst_size", o_instance_size, q[0].size);
                if (i_ready) void'(q.pop_front());
            end
        end
    end

    // Reference: J0 = IV||init, then ceil(pt_len/128) blocks with the low word counting up mod 2^32
    task automatic push_model(input logic [95:0] iv, input logic [63:0] aad, input logic [63:0] pt,
                              input logic [31:0] init);
        logic [64:0] nb65;
        logic [31:0] nb;
        exp_t e;
        nb65 = ({1'b0, pt} + 65'd127) / 65'd128;
        nb   = nb65[31:0];
        e.size = {aad, pt};
        e.blk  = {iv, init};
        e.j0   = 1'b1;
        e.last = (nb == 0);
        q.push_back(e);
        for (longint k = 1; k <= longint'(nb); k++) begin
            e.blk  = {iv, init + 32'(k)};
            e.j0   = 1'b0;
            e.last = (k == longint'(nb));
            q.push_back(e);
        end
    endtask

    task automatic start_inst(input logic [95:0] iv, input logic [63:0] aad, input logic [63:0] pt,
                              input logic ld, input logic [31:0] init);
        push_model(iv, aad, pt, ld ? init : 32'h00000001);
        i_start = 1'b1; i_iv = iv; i_aad_len = aad; i_pt_len = pt;
        i_ctr_load = ld; i_ctr_init = init;
        @(posedge clk); #1;
        // scramble the inputs so late re-sampling would be visible
        i_start = 1'b0; i_ctr_load = 1'b0;
        i_iv = {$urandom, $urandom, $urandom};
        i_aad_len = {$urandom, $urandom};
        i_pt_len = {$urandom, $urandom};
    endtask

    // Drain the queue (random or full ready), then check DRAIN/IDLE and that a start in DRAIN is dropped
    task automatic finish_inst(input bit rnd);
        int cyc = 0;
        while (q.size() > 0 && cyc < 3000) begin
            i_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        i_ready = 1'b0;
        if (q.size() != 0) begin
            checks++; failures++;
            $display("FAIL drain_timeout actual=%0d expected=0", q.size());
            q.delete();
        end
        chk("drain_valid", {127'd0, o_valid}, 128'd0);
        chk("drain_busy", {127'd0, o_busy}, 128'd1);
        i_start = 1'b1; i_pt_len = 64'd1000;
        @(posedge clk); #1;
        i_start = 1'b0;
        chk("idle_busy", {127'd0, o_busy}, 128'd0);
        chk("idle_valid", {127'd0, o_valid}, 128'd0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid_busy"}, {123'd0, o_valid, o_is_j0, o_new_instance, o_last, o_busy}, 128'd0);
        chk({tag, "_block"}, o_counter_block, 128'd0);
        chk({tag, "_size"}, o_instance_size, 128'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; i_start = 1'b0; i_iv = '0; i_aad_len = '0; i_pt_len = '0;
        i_ready = 1'b0; i_ctr_load = 1'b0; i_ctr_init = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("reset");
        // start during reset is ignored
        i_start = 1'b1; i_pt_len = 64'd256;
        @(posedge clk); #1;
        i_start = 1'b0;
        chk_reset_state("start_in_rst");
        rst = 1'b0;
        @(posedge clk); #1;

        // Known-answer instance
        start_inst(96'hCAFEBABEFACEDBADDECAF888, 64'd128, 64'd256, 1'b0, 32'h0);
        chk("kat_size", o_instance_size, 128'h0000000000000080_0000000000000100);
        finish_inst(1'b0);

        // Empty plaintext: J0 alone, marked last
        start_inst({$urandom, $urandom, $urandom}, 64'd64, 64'd0, 1'b0, 32'h0);
        finish_inst(1'b0);

        // Partial final block rounds up
        start_inst({$urandom, $urandom, $urandom}, 64'd0, 64'd129, 1'b0, 32'h0);
        finish_inst(1'b0);

        // 5-cycle stall on the second block (monitor re-checks it every stalled cycle)
        start_inst({$urandom, $urandom, $urandom}, 64'd32, 64'd384, 1'b0, 32'h0);
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        finish_inst(1'b0);

        // inc32 wrap: FFFFFFFE, FFFFFFFF, 00000000, 00000001 with IV untouched
        start_inst(96'hFFFFFFFF_FFFFFFFF_FFFFFFFF, 64'd0, 64'd384, 1'b1, 32'hFFFFFFFE);
        finish_inst(1'b0);

        // Start pulsed mid-instance while stalled and while transferring
        start_inst({$urandom, $urandom, $urandom}, 64'd512, 64'd640, 1'b0, 32'h0);
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0; i_start = 1'b1; i_pt_len = 64'd128; i_aad_len = 64'd7; i_iv = '1;
        @(posedge clk); #1;
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        finish_inst(1'b1);

        // Reset after 2 of 4 blocks, then a fresh start begins at J0
        start_inst({$urandom, $urandom, $urandom}, 64'd16, 64'd384, 1'b0, 32'h0);
        i_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        i_ready = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_state("mid_rst");
        q.delete();
        rst = 1'b0;
        @(posedge clk); #1;
        start_inst({$urandom, $urandom, $urandom}, 64'd8, 64'd200, 1'b0, 32'h0);
        finish_inst(1'b0);

        // Randomized instances with random back-pressure
        for (int t = 0; t < 12; t++) begin
            start_inst({$urandom, $urandom, $urandom}, {$urandom, $urandom},
                       64'($urandom_range(0, 1600)), 1'b0, 32'h0);
            finish_inst(1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
